// File: rtl/divisor_punto_fijo.sv
// -----------------------------------------------------------------------------
// divisor_punto_fijo
//   Sequential signed fixed-point divider, Q(Signo.Magnitud.Presicion), default
//   Q3.12 in 16 bits. Radix-2 restoring division, one quotient bit per clock.
//   The result format and saturation rules match the saturating adder and
//   multiplier chain, so the quotient can feed the adders directly.
//   Only one division is in flight at a time.
//
// Ports
//   clk       in   1      clock, rising edge
//   reset     in   1      synchronous, active-high; aborts a running division
//   start     in   1      request; A and B are sampled when ready=1
//   A         in   Width  signed dividend
//   B         in   Width  signed divisor
//   ready     out  1      idle, start will be accepted
//   done      out  1      one-cycle pulse, Y and flags are valid
//   Y         out  Width  signed quotient A/B, same Q format
//   overflow  out  1      result saturated (held until next accepted start)
//   div_zero  out  1      divisor was zero (held until next accepted start)
// -----------------------------------------------------------------------------
module divisor_punto_fijo #(
   parameter int Width     = 16,
   parameter int Signo     = 1,
   parameter int Magnitud  = 3,
   parameter int Presicion = 12
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [Width-1:0] A,
   input  logic signed [Width-1:0] B,
   output logic                    ready,
   output logic                    done,
   output logic signed [Width-1:0] Y,
   output logic                    overflow,
   output logic                    div_zero
);

   // Iteration count: Width-1+Presicion, written from the format fields.
   localparam int N  = Signo + Magnitud + 2 * Presicion - 1;
   localparam int CW = $clog2(N + 1);

   localparam logic [Width-1:0] POS_SAT = {1'b0, {(Width-1){1'b1}}};
   localparam logic [Width-1:0] NEG_SAT = {1'b1, {(Width-1){1'b0}}};
   localparam logic [N-1:0]     Q_MAX   = {{(N-Width+1){1'b0}}, {(Width-1){1'b1}}};
   localparam logic [N-1:0]     Q_MIN   = {{(N-Width){1'b0}}, 1'b1, {(Width-1){1'b0}}};
   localparam logic [CW-1:0]    LAST    = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t state, state_next;

   logic              sign;      // sign of the quotient
   logic              a_neg;     // sign of the dividend, used for the B==0 result
   logic              b_zero;
   logic              q_hi;      // quotient bit above the N iterated bits
   logic [CW-1:0]     count;
   logic [N-1:0]      dvd;       // remaining dividend bits, MSB first
   logic [N-1:0]      quo;
   logic [Width-1:0]  rem;
   logic [Width-1:0]  b_abs;

   logic [Width-1:0]  a_abs_in;
   logic [Width-1:0]  b_abs_in;
   logic [Width:0]    rem_sh;
   logic [Width-1:0]  diff;
   logic              ge;
   logic [Width:0]    fix_res;

   // Magnitude of a two's complement word; the most negative value maps to
   // itself, which is its correct unsigned magnitude in Width bits.
   function automatic logic [Width-1:0] abs_val(input logic signed [Width-1:0] v);
      logic [Width-1:0] u;
      u = v;
      return v[Width-1] ? (~u + 1'b1) : u;
   endfunction

   // Signed result with saturation; returns {overflow, Y}.
   function automatic logic [Width:0] saturate(input logic s, input logic hi,
                                               input logic [N-1:0] q);
      logic [Width-1:0] ql;
      ql = q[Width-1:0];
      if (!s && (hi || q > Q_MAX))
         return {1'b1, POS_SAT};
      else if (s && (hi || q > Q_MIN))
         return {1'b1, NEG_SAT};
      else if (s)
         return {1'b0, ~ql + 1'b1};
      else
         return {1'b0, ql};
   endfunction

   assign a_abs_in = abs_val(A);
   assign b_abs_in = abs_val(B);

   // Restoring step: shift in the next dividend bit, trial-subtract |B|.
   // The remainder stays below |B|, so a true difference always fits Width bits.
   always_comb begin
      rem_sh  = {rem, dvd[N-1]};
      ge      = (rem_sh >= {1'b0, b_abs});
      diff    = rem_sh[Width-1:0] - b_abs;
      fix_res = saturate(sign, q_hi, quo);
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = (B == '0) ? FIX : CALC;
         CALC: if (count == LAST) state_next = FIX;
         FIX:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ready = (state == IDLE);
   end

   // Datapath and registered results
   always_ff @(posedge clk) begin
      if (reset) begin
         sign     <= 1'b0;
         a_neg    <= 1'b0;
         b_zero   <= 1'b0;
         q_hi     <= 1'b0;
         count    <= '0;
         dvd      <= '0;
         quo      <= '0;
         rem      <= '0;
         b_abs    <= '0;
         done     <= 1'b0;
         Y        <= '0;
         overflow <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sign     <= A[Width-1] ^ B[Width-1];
               a_neg    <= A[Width-1];
               b_zero   <= (B == '0);
               b_abs    <= b_abs_in;
               count    <= '0;
               quo      <= '0;
               overflow <= 1'b0;
               div_zero <= 1'b0;
               // The full dividend |A|<<Presicion is N+1 bits wide. Its top bit
               // preloads the remainder; only |B|==1 could make it a quotient
               // bit, and that case is flagged as out of range instead.
               dvd      <= {a_abs_in[Width-2:0], {Presicion{1'b0}}};
               q_hi     <= a_abs_in[Width-1] && (b_abs_in == Width'(1));
               rem      <= {{(Width-1){1'b0}},
                            a_abs_in[Width-1] && (b_abs_in != Width'(1))};
            end
            CALC: begin
               rem   <= ge ? diff : rem_sh[Width-1:0];
               quo   <= {quo[N-2:0], ge};
               dvd   <= {dvd[N-2:0], 1'b0};
               count <= count + 1'b1;
            end
            FIX: begin
               done <= 1'b1;
               if (b_zero) begin
                  Y        <= a_neg ? NEG_SAT : POS_SAT;
                  overflow <= 1'b1;
                  div_zero <= 1'b1;
               end else begin
                  Y        <= fix_res[Width-1:0];
                  overflow <= fix_res[Width];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
